// File: rtl/i2c_codec_receiver.sv
// I2C write-only codec control receiver: START, device address, two data bytes, STOP -> 7-bit register address + 9-bit data.
// Optional 10x9 shadow register file under macro I2C_CODEC_SHADOW_EN. Latency: o_valid one clk after STOP is seen. No backpressure.
module i2c_codec_receiver #(
    parameter logic [6:0] DEV_ADDR    = 7'b0011010,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_oen,
    output logic       o_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic [7:0] o_frame_cnt,
    output logic       o_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic start_det, stop_det, scl_rise, scl_fall;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] shreg, shreg_n;
    logic [7:0] byte1, byte1_n, byte2, byte2_n;
    logic       ack_drive, ack_n;
    logic       err_q, err_n, valid_q, valid_n;
    logic       in_frame;
    logic [7:0] cur_byte;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_sclk};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sdat};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign start_det = scl_s && scl_d && sda_d && !sda_s;
    assign stop_det  = scl_s && scl_d && !sda_d && sda_s;
    assign scl_rise  = scl_s && !scl_d;
    assign scl_fall  = !scl_s && scl_d;

    assign in_frame = (state != IDLE) && (state != WAIT_STOP);
    assign cur_byte = {shreg, sda_s};

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        byte1_n   = byte1;
        byte2_n   = byte2;
        ack_n     = ack_drive;
        err_n     = 1'b0;
        valid_n   = 1'b0;
        // STOP wins over START; both abort a frame that has not reached WAIT_STOP
        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            ack_n     = 1'b0;
            err_n     = in_frame;
            valid_n   = (state == WAIT_STOP);
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            ack_n     = 1'b0;
            err_n     = in_frame;
        end else begin
            case (state)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise) begin
                        shreg_n   = cur_byte[6:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ADDR) begin
                                if (cur_byte == {DEV_ADDR, 1'b0}) begin
                                    state_n = ACK_A;
                                end else begin
                                    state_n = IDLE;
                                    err_n   = 1'b1;
                                end
                            end else if (state == BYTE1) begin
                                byte1_n = cur_byte;
                                state_n = ACK1;
                            end else begin
                                byte2_n = cur_byte;
                                state_n = ACK2;
                            end
                        end
                    end
                end
                ACK_A, ACK1, ACK2: begin
                    // first SCL fall after bit 8 pulls SDA low, the next one releases it
                    if (scl_fall) begin
                        if (!ack_drive) begin
                            ack_n = 1'b1;
                        end else begin
                            ack_n   = 1'b0;
                            state_n = (state == ACK_A) ? BYTE1 :
                                      (state == ACK1)  ? BYTE2 : WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            byte1       <= 8'd0;
            byte2       <= 8'd0;
            ack_drive   <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            o_reg_addr  <= 7'd0;
            o_reg_data  <= 9'd0;
            o_frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            byte1     <= byte1_n;
            byte2     <= byte2_n;
            ack_drive <= ack_n;
            err_q     <= err_n;
            valid_q   <= valid_n;
            if (valid_n) begin
                o_reg_addr  <= byte1[7:1];
                o_reg_data  <= {byte1[0], byte2};
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end
        end
    end

    assign o_oen   = ~ack_drive;
    assign o_valid = valid_q;
    assign o_err   = err_q;

`ifdef I2C_CODEC_SHADOW_EN
    logic [8:0] shadow [0:9];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 10; i++) shadow[i] <= 9'd0;
        end else if (valid_n) begin
            if (byte1[7:1] == 7'h0F) begin
                for (int i = 0; i < 10; i++) shadow[i] <= 9'd0;
            end else if (byte1[7:1] <= 7'd9) begin
                shadow[byte1[4:1]] <= {byte1[0], byte2};
            end
        end
    end

    assign o_rd_data = (i_rd_addr <= 4'd9) ? shadow[i_rd_addr] : 9'd0;
`else
    logic unused_rd;
    assign unused_rd = ^i_rd_addr;
    assign o_rd_data = 9'd0;
`endif

endmodule

// File: tb/tb_i2c_codec_receiver.sv
// Directed bench for i2c_codec_receiver: bit-banged I2C master with a wired-AND SDA bus.
module tb_i2c_codec_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic [3:0] rd_addr;
    logic       oen, valid, err;
    logic [6:0] reg_addr;
    logic [8:0] reg_data, rd_data;
    logic [7:0] frame_cnt;
    logic       sdat_bus;

    always #5 clk = ~clk;

    assign sdat_bus = sda_m & oen;

    i2c_codec_receiver dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sclk     (scl_m),
        .i_sdat     (sdat_bus),
        .o_oen      (oen),
        .o_valid    (valid),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_frame_cnt(frame_cnt),
        .o_err      (err),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    int q = 8;
    int n_checks = 0;
    int n_fails = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        scl_m = 1'b1;
        sda_m = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        scl_m = 1'b1;
        tick(q);
        sda_m = 1'b0;
        tick(q);
        scl_m = 1'b0;
        tick(q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(q);
        scl_m = 1'b1;
        tick(q);
        sda_m = 1'b1;
        tick(q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(q);
        scl_m = 1'b1;
        tick(q);
        scl_m = 1'b0;
        tick(q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // ninth clock: master releases SDA, ack is sampled while SCL is high
    task automatic ack_slot(output int ack);
        sda_m = 1'b1;
        tick(q);
        scl_m = 1'b1;
        tick(q - 1);
        @(negedge clk);
        ack = (oen === 1'b0) ? 1 : 0;
        @(posedge clk);
        scl_m = 1'b0;
        tick(q);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              output int acks);
        int a;
        acks = 0;
        i2c_start();
        send_bits(b0); ack_slot(a); acks += a;
        send_bits(b1); ack_slot(a); acks += a;
        send_bits(b2); ack_slot(a); acks += a;
        i2c_stop();
        tick(4);
    endtask

    initial begin
        int acks, a, v0, e0, w, total_acks;
        logic [7:0] b1s [7];
        logic [7:0] b2s [7];

        rd_addr = 4'd0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        check("reset_oen", 32'(oen), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_reg_addr", 32'(reg_addr), 32'd0);
        check("reset_reg_data", 32'(reg_data), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // basic write: reg 0x04 <= 0x015
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h34, 8'h08, 8'h15, acks);
        @(negedge clk);
        check("basic_acks", 32'(acks), 32'd3);
        check("basic_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("basic_err_pulses", 32'(err_cnt - e0), 32'd0);
        check("basic_reg_addr", 32'(reg_addr), 32'h04);
        check("basic_reg_data", 32'(reg_data), 32'h015);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        check("basic_oen_idle", 32'(oen), 32'd1);

        // seven back-to-back writes from a fresh reset
        do_reset();
        b1s = '{8'h1E, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
        b2s = '{8'h00, 8'h15, 8'h00, 8'h00, 8'h42, 8'h19, 8'h01};
        v0 = valid_cnt;
        total_acks = 0;
        for (int i = 0; i < 7; i++) begin
            send_frame(8'h34, b1s[i], b2s[i], acks);
            total_acks += acks;
        end
        @(negedge clk);
        check("seven_acks", 32'(total_acks), 32'd21);
        check("seven_valid_pulses", 32'(valid_cnt - v0), 32'd7);
        check("seven_frame_cnt", 32'(frame_cnt), 32'd7);
        check("seven_reg_addr", 32'(reg_addr), 32'h09);
        check("seven_reg_data", 32'(reg_data), 32'h001);
        rd_addr = 4'd7;
        #1;
`ifdef I2C_CODEC_SHADOW_EN
        check("shadow_rd7", 32'(rd_data), 32'h042);
`else
        check("shadow_rd7", 32'(rd_data), 32'h000);
`endif
        rd_addr = 4'd4;
        #1;
`ifdef I2C_CODEC_SHADOW_EN
        check("shadow_rd4", 32'(rd_data), 32'h015);
`else
        check("shadow_rd4", 32'(rd_data), 32'h000);
`endif
        rd_addr = 4'd3;
        #1;
        check("shadow_rd3_unwritten", 32'(rd_data), 32'h000);
        rd_addr = 4'd12;
        #1;
        check("shadow_rd12_out_of_range", 32'(rd_data), 32'h000);
        rd_addr = 4'd0;

        // wrong device address: no ack, one error pulse
        v0 = valid_cnt; e0 = err_cnt;
        i2c_start();
        send_bits(8'h36);
        ack_slot(a);
        i2c_stop();
        tick(4);
        @(negedge clk);
        check("badaddr_ack", 32'(a), 32'd0);
        check("badaddr_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("badaddr_valid_pulses", 32'(valid_cnt - v0), 32'd0);

        // STOP after only the first data byte
        v0 = valid_cnt; e0 = err_cnt;
        i2c_start();
        send_bits(8'h34); ack_slot(a);
        send_bits(8'h08); ack_slot(a);
        i2c_stop();
        tick(4);
        @(negedge clk);
        check("short_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("short_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        check("short_reg_addr", 32'(reg_addr), 32'h09);
        check("short_reg_data", 32'(reg_data), 32'h001);
        check("short_frame_cnt", 32'(frame_cnt), 32'd7);

        // reset while the block is driving the ACK of byte 1
        v0 = valid_cnt; e0 = err_cnt;
        i2c_start();
        send_bits(8'h34); ack_slot(a);
        send_bits(8'h08);
        w = 0;
        while (oen !== 1'b0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        @(negedge clk);
        check("ack1_oen_low", 32'(oen), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("ack1_reset_releases_sda", 32'(oen), 32'd1);
        rst_n = 1'b1;
        sda_m = 1'b1;
        tick(q);
        scl_m = 1'b1;
        tick(q);
        scl_m = 1'b0;
        tick(q);
        i2c_stop();
        tick(4);
        @(negedge clk);
        check("ack1_reset_no_err", 32'(err_cnt - e0), 32'd0);
        check("ack1_reset_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(8'h34, 8'h10, 8'h19, acks);
        @(negedge clk);
        check("after_reset_acks", 32'(acks), 32'd3);
        check("after_reset_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("after_reset_frame_cnt", 32'(frame_cnt), 32'd1);
        check("after_reset_reg_addr", 32'(reg_addr), 32'h08);
        check("after_reset_reg_data", 32'(reg_data), 32'h019);

        // frame counter wrap, faster bus
        q = 3;
        do_reset();
        v0 = valid_cnt;
        total_acks = 0;
        for (int i = 0; i < 255; i++) begin
            send_frame(8'h34, 8'h14, 8'hA5, acks);
            total_acks += acks;
        end
        @(negedge clk);
        check("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        send_frame(8'h34, 8'h14, 8'hA5, acks);
        total_acks += acks;
        @(negedge clk);
        check("wrap_cnt_0", 32'(frame_cnt), 32'd0);
        check("wrap_valid_pulses", 32'(valid_cnt - v0), 32'd256);
        check("wrap_acks", 32'(total_acks), 32'd768);
        check("wrap_reg_addr", 32'(reg_addr), 32'h0A);
        check("wrap_reg_data", 32'(reg_data), 32'h0A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/i2c_codec_receiver.md
I2C_CODEC_RECEIVER -- requirements
Module: i2c_codec_receiver

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'b0011010, giving the 7-bit I2C device address it answers to; write byte 0x34.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on i_sclk and i_sdat.
REQ-003 Port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port i_sclk, input, 1 bit: I2C SCL from the bus master, asynchronous to i_clk.
REQ-006 Port i_sdat, input, 1 bit: I2C SDA as resolved on the bus, asynchronous.
REQ-007 Port o_oen, output, 1 bit: 1 releases SDA (high-Z); 0 drives SDA low, used only for ACK.
REQ-008 Port o_valid, output, 1 bit: one-cycle pulse when a complete register write has been accepted.
REQ-009 Port o_reg_addr, output, 7 bits: register address of the last accepted write.
REQ-010 Port o_reg_data, output, 9 bits: register data of the last accepted write.
REQ-011 Port o_frame_cnt, output, 8 bits: count of accepted writes.
REQ-012 Port o_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-013 Port i_rd_addr, input, 4 bits: shadow register read address.
REQ-014 Port o_rd_data, output, 9 bits: shadow register read data.

Function
REQ-015 i_sclk and i_sdat SHALL pass through SYNC_STAGES flops; edge detection compares the last two synchronized samples.
REQ-016 START SHALL be SDA falling while SCL is high; STOP SHALL be SDA rising while SCL is high.
REQ-017 Data bits SHALL be sampled MSB first on the synchronized SCL rising edge.
REQ-018 The FSM SHALL have the states IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP. START from any state goes to ADDR and clears the 3-bit bit counter.
REQ-019 After the 8th ADDR bit: if the byte equals {DEV_ADDR,1'b0}, go to ACK_A; otherwise pulse o_err and go to IDLE with o_oen held at 1.
REQ-020 In each ACK state, o_oen SHALL go 0 on the SCL falling edge after bit 8 and return to 1 on the next SCL falling edge, then advance: ACK_A to BYTE1, ACK1 to BYTE2, ACK2 to WAIT_STOP.
REQ-021 On STOP in WAIT_STOP, the block SHALL, in the cycle after detection, pulse o_valid for 1 cycle, with o_reg_addr = byte1[7:1] and o_reg_data = {byte1[0], byte2}.
REQ-022 On the same cycle as the o_valid pulse, o_frame_cnt SHALL increment, wrapping from 255 to 0.
REQ-023 STOP or repeated START in any state from ADDR through ACK2 SHALL discard the partial frame and pulse o_err; o_valid is not asserted.
REQ-024 Extra SCL bits in WAIT_STOP SHALL be ignored, with no ACK driven.
REQ-025 o_reg_addr and o_reg_data SHALL hold their values between accepted writes.
REQ-026 If START and STOP are flagged in the same cycle, STOP SHALL take priority.

Reset
REQ-027 While i_rst_n=0 at a clock edge: FSM goes to IDLE, o_oen=1, o_valid=0, o_err=0, o_reg_addr=0, o_reg_data=0, o_frame_cnt=0, synchronizer flops are set to 1, and shadow registers are cleared to 0.
REQ-028 Reset in mid-frame SHALL release SDA on the next clock edge and SHALL NOT produce o_valid or o_err.

Configuration
REQ-029 With macro I2C_CODEC_SHADOW_EN defined, the block SHALL contain a 10x9 shadow register file for addresses 0-9.
- Each accepted write to address 0-9 updates its entry.
- A write to address 0x0F clears all entries.
- Writes to any other address do not change the shadow.
- o_rd_data = shadow[i_rd_addr], combinational; 0 when i_rd_addr > 9.
REQ-030 Without I2C_CODEC_SHADOW_EN, o_rd_data SHALL be tied to 0 and no shadow storage is built; all ports exist in both builds.

Verification
REQ-031 Frame START,0x34,0x08,0x15,STOP -> three ACKs (o_oen low for one SCL period each); o_valid pulse; o_reg_addr=7'h04; o_reg_data=9'h015; o_frame_cnt=1.
REQ-032 Seven back-to-back frames (addr 0x0F/0x0000, 0x04/0x015, 0x05/0x000, 0x06/0x000, 0x07/0x042, 0x08/0x019, 0x09/0x001) -> seven o_valid pulses; o_frame_cnt=7; with SHADOW_EN, o_rd_data=0x042 at i_rd_addr=7.
REQ-033 Address byte 0x36 -> no ACK (o_oen stays 1); one o_err pulse; o_valid stays 0.
REQ-034 STOP after BYTE1 only -> one o_err pulse; o_reg_addr and o_reg_data unchanged; o_frame_cnt unchanged.
REQ-035 i_rst_n=0 for one cycle while o_oen=0 in ACK1 -> o_oen=1 next cycle; a following full frame is accepted normally.
REQ-036 256 accepted frames -> o_frame_cnt wraps to 0.
